// File: rtl/dmem_responder.sv
// Word-organised data RAM behind the MEM stage.
// Fixed-latency access with stall and a one-cycle completion pulse.
module dmem_responder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_re,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              stall,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  typedef struct packed {
    logic              re;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        be;
  } req_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  misalign;
  logic                  oor;
  logic                  acc_err;
  logic                  access;
  logic                  wr_en;
  logic                  new_req;

  assign new_req  = req_re | req_we;
  assign idx      = req_q.addr[DEPTH_LOG2+1:2];
  assign misalign = |req_q.addr[1:0];
  assign oor      = |(req_q.addr >> (DEPTH_LOG2 + 2));
  assign acc_err  = misalign | oor
                  | (req_q.re & req_q.we);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    access  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (new_req) begin
          req_d.re    = req_re;
          req_d.we    = req_we;
          req_d.addr  = req_addr;
          req_d.wdata = req_wdata;
          req_d.be    = req_be;
          cnt_d       = CNT_W'(LATENCY - 1);
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          access  = 1'b1;
          err_d   = acc_err;
          state_d = S_DONE;
          if (!acc_err && req_q.re) begin
            rdata_d = mem_q[idx];
          end else begin
            rdata_d = '0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM is not reset; gating on rst keeps a racing reset from committing
  assign wr_en = rst & access
               & req_q.we & ~acc_err;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (req_q.be[b]) begin
          mem_q[idx][8*b +: 8] <= req_q.wdata[8*b +: 8];
        end
      end
    end
  end

  assign stall = rst
               & ((state_q == S_BUSY)
               | ((state_q == S_IDLE) & new_req));

  assign rdata_valid = (state_q == S_DONE);
  assign rdata       = rdata_q;
  assign err         = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder.
// Driver pushes expected responses; monitor pops on rdata_valid.
module tb_dmem_responder;

  localparam int LAT = 2;
  localparam int LIMIT = 32'h1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_re = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        stall;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        err;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        dc;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl [int];
  int          n_assert = 0;
  int          n_fail = 0;
  int          n_issued = 0;
  int          n_valid = 0;

  dmem_responder #(
    .DATA_W(32),
    .ADDR_W(32),
    .DEPTH_LOG2(10),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_re(req_re),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_be(req_be),
    .stall(stall),
    .rdata_valid(rdata_valid),
    .rdata(rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic exp_t model(logic re, logic we,
                                 logic [31:0] addr,
                                 logic [31:0] wd,
                                 logic [3:0] be);
    exp_t e;
    int w;
    logic [31:0] old;
    e.data = 32'h0;
    e.err  = 1'b0;
    e.dc   = 1'b0;
    w = int'(addr / 4);
    if ((addr % 4) != 0 || addr >= LIMIT || (re && we)) begin
      e.err = 1'b1;
    end else if (we) begin
      old = mdl.exists(w) ? mdl[w] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
      if (mdl.exists(w) || be == 4'hF) mdl[w] = old;
    end else if (mdl.exists(w)) begin
      e.data = mdl[w];
    end else begin
      e.dc = 1'b1;
    end
    return e;
  endfunction

  task automatic drive(logic re, logic we,
                       logic [31:0] a,
                       logic [31:0] wd,
                       logic [3:0] be);
    req_re    = re;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
  endtask

  // cycles 1..LAT busy, then the DONE cycle
  task automatic check_timing();
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("stall_busy", 32'(stall), 32'd1);
      chk("valid_busy", 32'(rdata_valid), 32'd0);
    end
    @(negedge clk);
    chk("stall_done", 32'(stall), 32'd0);
    chk("valid_done", 32'(rdata_valid), 32'd1);
  endtask

  task automatic issue(logic re, logic we,
                       logic [31:0] a,
                       logic [31:0] wd,
                       logic [3:0] be);
    @(posedge clk);
    #1;
    drive(re, we, a, wd, be);
    sb.push_back(model(re, we, a, wd, be));
    n_issued++;
    @(negedge clk);
    chk("stall_accept", 32'(stall), 32'd1);
    chk("valid_accept", 32'(rdata_valid), 32'd0);
    check_timing();
  endtask

  task automatic idle(int n);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (n) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (rst && rdata_valid) begin
      exp_t e;
      n_valid++;
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got 1 expected 0");
      end else begin
        n_assert--;
        e = sb.pop_front();
        chk("err", 32'(err), 32'(e.err));
        if (!e.dc) chk("rdata", rdata, e.data);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    int kind;

    #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_valid", 32'(rdata_valid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    sb.push_back(model(1'b1, 1'b0, 32'h10, 32'h0, 4'hF));
    n_issued++;
    #1;
    chk("rel_stall", 32'(stall), 32'd1);
    check_timing();
    idle(1);

    for (int i = 0; i < 16; i++)
      issue(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF);

    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    issue(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    issue(1'b1, 1'b0, 32'h12, 32'h0, 4'hF);
    issue(1'b0, 1'b1, 32'h1000, 32'h55555555, 4'hF);
    issue(1'b1, 1'b1, 32'h10, 32'h66666666, 4'hF);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    issue(1'b0, 1'b1, 32'h10, 32'h77777777, 4'h0);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    issue(1'b0, 1'b1, 32'hFFC, 32'hA5A5F00F, 4'hF);
    issue(1'b1, 1'b0, 32'hFFC, 32'h0, 4'hF);

    issue(1'b0, 1'b1, 32'h20, 32'h00000001, 4'hF);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_valid", 32'(rdata_valid), 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abandoned_valid", 32'(rdata_valid), 32'd0);
    end
    issue(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);

    issue(1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    issue(1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
    issue(1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
    idle(2);

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      a  = 32'($urandom_range(0, 15) * 4);
      wd = $urandom;
      case (kind)
        0: issue(1'b1, 1'b0, a | 32'($urandom_range(1, 3)),
                 wd, 4'hF);
        1: issue($urandom_range(0, 1) == 1, 1'b1,
                 32'h1000 + ($urandom & 32'hFFFF_FFFC),
                 wd, 4'hF);
        2: issue(1'b1, 1'b1, a, wd, 4'(($urandom)));
        3, 4, 5: issue(1'b0, 1'b1, a, wd, 4'($urandom));
        default: issue(1'b1, 1'b0, a, wd, 4'($urandom));
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end
    idle(4);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("valid_count", 32'(n_valid), 32'(n_issued));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
